i2c_sb_sequencer: RTL and testbench

I2C_SB_SEQUENCER -- requirements
Module: i2c_sb_sequencer

---
 rtl/i2c_sb_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_sb_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sb_sequencer.sv
// i2c_sb_sequencer: runs I2C register reads/writes through the SB_I2C hard-IP system bus
module i2c_sb_sequencer #(
    parameter logic [9:0]  PRESCALE   = 10'd15,
    parameter logic [15:0] POLL_LIMIT = 16'd50000,
    parameter logic [3:0]  BUS_ADDR74 = 4'b0001
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    output logic       sb_stb,
    output logic       sb_rw,
    output logic [7:0] sb_adr,
    output logic [7:0] sb_dato,
    input  logic [7:0] sb_dati,
    input  logic       sb_ack
);
    localparam logic [3:0] CR1 = 4'h8, CMDR = 4'h9, BRLSB = 4'hA, BRMSB = 4'hB;
    localparam logic [3:0] SR = 4'hC, TXDR = 4'hD, RXDR = 4'hE;

    typedef enum logic [3:0] {
        INIT_CR1, INIT_BRL, INIT_BRH, IDLE, TXD, CMD, POLL, CHK, RXD, STOP, STOP_POLL, RESP
    } state_t;

    state_t      state_q, state_d;
    logic        sb_stb_q, sb_stb_d, sb_rw_q, sb_rw_d;
    logic [7:0]  sb_adr_q, sb_adr_d, sb_dato_q, sb_dato_d;
    logic        cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
    logic        rsp_nack_q, rsp_nack_d, rsp_timeout_q, rsp_timeout_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        op_rw_q, op_rw_d;
    logic [6:0]  op_dev_q, op_dev_d;
    logic [7:0]  op_reg_q, op_reg_d, op_wdata_q, op_wdata_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        rarc_q, rarc_d;
    logic [7:0]  rx_q, rx_d;

    logic        acc_en, acc_wr, done;
    logic [3:0]  acc_off;
    logic [7:0]  acc_dat, tx_byte, cmd_byte;
    logic [15:0] poll_inc;

    // Step 0 addresses the device, step 1 sends the register, step 2 sends data or the
    // repeated-start address, step 3 is the single-byte read with NACK
    assign tx_byte  = step_q == 2'd0 ? {op_dev_q, 1'b0} : step_q == 2'd1 ? op_reg_q :
                      op_rw_q ? {op_dev_q, 1'b1} : op_wdata_q;
    assign cmd_byte = step_q == 2'd3 ? 8'h2C :
                      (step_q == 2'd0 || (step_q == 2'd2 && op_rw_q)) ? 8'h94 : 8'h14;
    assign done     = sb_stb_q & sb_ack;
    assign poll_inc = poll_cnt_q + 16'd1;

    // Bus access each state needs: direction, register offset and write byte
    always_comb begin
        acc_en  = 1'b1;
        acc_wr  = 1'b1;
        acc_off = CMDR;
        acc_dat = 8'h00;
        case (state_q)
            INIT_CR1:        begin acc_off = CR1;   acc_dat = 8'h80; end
            INIT_BRL:        begin acc_off = BRLSB; acc_dat = PRESCALE[7:0]; end
            INIT_BRH:        begin acc_off = BRMSB; acc_dat = {6'b0, PRESCALE[9:8]}; end
            TXD:             begin acc_off = TXDR;  acc_dat = tx_byte; end
            CMD:             acc_dat = cmd_byte;
            STOP:            acc_dat = 8'h44;
            POLL, STOP_POLL: begin acc_wr = 1'b0; acc_off = SR; end
            RXD:             begin acc_wr = 1'b0; acc_off = RXDR; end
            default:         acc_en = 1'b0;
        endcase
    end

    // Sequencer next state, bus handshake and response bookkeeping
    always_comb begin
        state_d       = state_q;
        sb_stb_d      = sb_stb_q;
        sb_rw_d       = sb_rw_q;
        sb_adr_d      = sb_adr_q;
        sb_dato_d     = sb_dato_q;
        rsp_nack_d    = rsp_nack_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        op_rw_d       = op_rw_q;
        op_dev_d      = op_dev_q;
        op_reg_d      = op_reg_q;
        op_wdata_d    = op_wdata_q;
        step_d        = step_q;
        poll_cnt_d    = poll_cnt_q;
        rarc_d        = rarc_q;
        rx_d          = rx_q;
        if (done)
            sb_stb_d = 1'b0;
        else if (acc_en && !sb_stb_q) begin
            sb_stb_d  = 1'b1;
            sb_rw_d   = acc_wr;
            sb_adr_d  = {BUS_ADDR74, acc_off};
            sb_dato_d = acc_wr ? acc_dat : 8'h00;
        end
        case (state_q)
            INIT_CR1: if (done) state_d = INIT_BRL;
            INIT_BRL: if (done) state_d = INIT_BRH;
            INIT_BRH: if (done) state_d = IDLE;
            IDLE: if (cmd_valid) begin
                op_rw_d       = cmd_rw;
                op_dev_d      = cmd_dev;
                op_reg_d      = cmd_reg;
                op_wdata_d    = cmd_wdata;
                rsp_nack_d    = 1'b0;
                rsp_timeout_d = 1'b0;
                step_d        = 2'd0;
                state_d       = TXD;
            end
            TXD: if (done) state_d = CMD;
            CMD: if (done) begin
                poll_cnt_d = 16'd0;
                state_d    = POLL;
            end
            POLL: if (done) begin
                poll_cnt_d = poll_inc;
                rarc_d     = sb_dati[5];
                if (sb_dati[2])
                    state_d = step_q == 2'd3 ? RXD : CHK;
                else if (poll_inc >= POLL_LIMIT) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = STOP;
                end
            end
            CHK: begin
                if (rarc_q) begin
                    rsp_nack_d = 1'b1;
                    state_d    = STOP;
                end else if (step_q == 2'd2 && !op_rw_q)
                    state_d = STOP;
                else begin
                    step_d  = step_q + 2'd1;
                    state_d = step_q == 2'd2 ? CMD : TXD;
                end
            end
            RXD: if (done) begin
                rx_d    = sb_dati;
                state_d = STOP;
            end
            STOP: if (done) begin
                poll_cnt_d = 16'd0;
                state_d    = STOP_POLL;
            end
            STOP_POLL: if (done) begin
                poll_cnt_d = poll_inc;
                if (!sb_dati[6] || poll_inc >= POLL_LIMIT) begin
                    rsp_timeout_d = rsp_timeout_q | sb_dati[6];
                    rsp_rdata_d   = (op_rw_q && !rsp_nack_q && !rsp_timeout_d) ? rx_q : 8'h00;
                    state_d       = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = INIT_CR1;
        endcase
        cmd_ready_d = state_d == IDLE;
        rsp_valid_d = state_d == RESP;
    end

    // State and registered outputs; reset aborts any transfer without a STOP
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= INIT_CR1;
            sb_stb_q      <= 1'b0;
            sb_rw_q       <= 1'b0;
            sb_adr_q      <= 8'h00;
            sb_dato_q     <= 8'h00;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_nack_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            op_rw_q       <= 1'b0;
            op_dev_q      <= 7'h00;
            op_reg_q      <= 8'h00;
            op_wdata_q    <= 8'h00;
            step_q        <= 2'd0;
            poll_cnt_q    <= 16'd0;
            rarc_q        <= 1'b0;
            rx_q          <= 8'h00;
        end else begin
            state_q       <= state_d;
            sb_stb_q      <= sb_stb_d;
            sb_rw_q       <= sb_rw_d;
            sb_adr_q      <= sb_adr_d;
            sb_dato_q     <= sb_dato_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_nack_q    <= rsp_nack_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            op_rw_q       <= op_rw_d;
            op_dev_q      <= op_dev_d;
            op_reg_q      <= op_reg_d;
            op_wdata_q    <= op_wdata_d;
            step_q        <= step_d;
            poll_cnt_q    <= poll_cnt_d;
            rarc_q        <= rarc_d;
            rx_q          <= rx_d;
        end
    end

    assign sb_stb      = sb_stb_q;
    assign sb_rw       = sb_rw_q;
    assign sb_adr      = sb_adr_q;
    assign sb_dato     = sb_dato_q;
    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_nack    = rsp_nack_q;
    assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_i2c_sb_sequencer.sv
// tb_i2c_sb_sequencer: directed vectors against an SB_I2C bus model with configurable ack latency
module tb_i2c_sb_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
    logic [6:0] cmd_dev = 7'h00;
    logic [7:0] cmd_reg = 8'h00, cmd_wdata = 8'h00;
    logic       rsp_valid, rsp_nack, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       sb_stb, sb_rw;
    logic [7:0] sb_adr, sb_dato;
    logic [7:0] sb_dati = 8'h00;
    logic       sb_ack = 1'b0;

    i2c_sb_sequencer #(.PRESCALE(10'd15), .POLL_LIMIT(16'd4), .BUS_ADDR74(4'b0001)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
        .sb_stb(sb_stb), .sb_rw(sb_rw), .sb_adr(sb_adr), .sb_dato(sb_dato),
        .sb_dati(sb_dati), .sb_ack(sb_ack)
    );

    always #5 clock = ~clock;

    typedef struct { logic rw; logic [7:0] adr; logic [7:0] dat; } acc_t;
    typedef struct {
        logic        rw;
        logic [6:0]  dev;
        logic [7:0]  rg, wd, sr, rx;
        int          pre;
        logic        hold;
        logic [7:0]  e_rdata;
        logic        e_nack, e_to;
        logic [31:0] e_tx;
        int          e_txn;
        logic [39:0] e_cmd;
        int          e_cmdn;
        int          e_srn;
    } vec_t;

    acc_t       log_q[$];
    vec_t       vecs[8];
    int         checks = 0, errors = 0;
    int         ack_delay = 0, sr_pre = 0, wcnt = 0;
    logic [7:0] sr_val = 8'h04, rx_val = 8'h00;
    logic       busy = 1'b0;
    logic [16:0] snap = '0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SB_I2C slave: acks after ack_delay extra cycles, SR stalls at 0x00 for sr_pre reads
    always @(negedge clock) begin
        if (sb_ack) begin
            sb_ack = 1'b0;
            chk("stb_gap", 48'(sb_stb), 48'd0);
        end else if (sb_stb) begin
            if (!busy) begin
                busy = 1'b1;
                wcnt = 0;
                snap = {sb_rw, sb_adr, sb_dato};
            end
            if (wcnt == ack_delay) begin
                chk("stb_hold", 48'({sb_rw, sb_adr, sb_dato}), 48'(snap));
                if (!sb_rw) begin
                    chk("rd_dato", 48'(sb_dato), 48'd0);
                    if (sb_adr == 8'h1C) begin
                        sb_dati = sr_pre > 0 ? 8'h00 : sr_val;
                        if (sr_pre > 0) sr_pre--;
                    end else
                        sb_dati = sb_adr == 8'h1E ? rx_val : 8'hEE;
                end
                log_q.push_back('{sb_rw, sb_adr, sb_rw ? sb_dato : sb_dati});
                sb_ack = 1'b1;
                busy = 1'b0;
            end else
                wcnt++;
        end else
            busy = 1'b0;
    end

    task automatic check_init(input string name);
        logic [47:0] pk = '0;
        int n = 0;
        bit ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clock);
            ok = cmd_ready;
        end
        chk({name, "_ready"}, 48'(ok), 48'd1);
        foreach (log_q[j]) begin
            pk = {pk[31:0], log_q[j].adr, log_q[j].dat};
            n += log_q[j].rw ? 1 : 100;
        end
        chk({name, "_writes"}, pk, 48'h18801A0F1B00);
        chk({name, "_count"}, 48'(n), 48'd3);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        logic [31:0] tx = '0;
        logic [39:0] cm = '0;
        int txn = 0, cmn = 0, srn = 0;
        bit ok = 0;
        v = vecs[i];
        @(negedge clock);
        log_q.delete();
        sr_val = v.sr;
        rx_val = v.rx;
        sr_pre = v.pre;
        cmd_rw = v.rw;
        cmd_dev = v.dev;
        cmd_reg = v.rg;
        cmd_wdata = v.wd;
        cmd_valid = 1'b1;
        for (int k = 0; k < 500 && !ok; k++) begin
            if (cmd_ready) ok = 1;
            else @(negedge clock);
        end
        chk($sformatf("v%0d_accept", i), 48'(ok), 48'd1);
        @(posedge clock);
        #1;
        cmd_valid = v.hold;
        cmd_rw = ~v.rw;
        cmd_dev = 7'h33;
        cmd_reg = 8'hCC;
        cmd_wdata = 8'h5A;
        ok = 0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clock);
            ok = rsp_valid;
        end
        cmd_valid = 1'b0;
        chk($sformatf("v%0d_rsp_seen", i), 48'(ok), 48'd1);
        chk($sformatf("v%0d_rsp", i), 48'({rsp_rdata, rsp_nack, rsp_timeout}),
            48'({v.e_rdata, v.e_nack, v.e_to}));
        foreach (log_q[j]) begin
            if (log_q[j].rw && log_q[j].adr == 8'h1D) begin tx = {tx[23:0], log_q[j].dat}; txn++; end
            if (log_q[j].rw && log_q[j].adr == 8'h19) begin cm = {cm[31:0], log_q[j].dat}; cmn++; end
            if (!log_q[j].rw && log_q[j].adr == 8'h1C) srn++;
        end
        chk($sformatf("v%0d_txdr", i), 48'({8'(txn), tx}), 48'({8'(v.e_txn), v.e_tx}));
        chk($sformatf("v%0d_cmdr", i), {8'(cmn), cm}, {8'(v.e_cmdn), v.e_cmd});
        chk($sformatf("v%0d_sr_reads", i), 48'(srn), 48'(v.e_srn));
        @(negedge clock);
        chk($sformatf("v%0d_after", i), 48'({rsp_valid, cmd_ready, rsp_rdata}),
            48'({1'b0, 1'b1, v.e_rdata}));
    endtask

    initial begin
        bit ok;
        //          rw    dev    reg    wdata  sr     rx    pre hold  rdata  nk  to    txdr            n  cmdr               n  sr
        vecs[0] = '{1'b0, 7'h48, 8'h01, 8'hA5, 8'h04, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h9001A5, 3, 40'h94141444, 4, 4};
        vecs[1] = '{1'b1, 7'h48, 8'h00, 8'h00, 8'h04, 8'h3C, 0, 1'b0, 8'h3C, 1'b0, 1'b0, 32'h900091, 3, 40'h9414942C44, 5, 5};
        vecs[2] = '{1'b1, 7'h48, 8'h00, 8'h00, 8'h24, 8'h3C, 0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h90, 1, 40'h9444, 2, 2};
        vecs[3] = '{1'b0, 7'h48, 8'h01, 8'hA5, 8'h04, 8'h00, 100, 1'b0, 8'h00, 1'b0, 1'b1, 32'h90, 1, 40'h9444, 2, 5};
        vecs[4] = '{1'b1, 7'h2A, 8'h7F, 8'h00, 8'h04, 8'hC3, 3, 1'b0, 8'hC3, 1'b0, 1'b0, 32'h547F55, 3, 40'h9414942C44, 5, 8};
        vecs[5] = '{1'b1, 7'h01, 8'h10, 8'h00, 8'h44, 8'h99, 0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h021003, 3, 40'h9414942C44, 5, 8};
        vecs[6] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 8'h44, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b1, 32'hFEFF00, 3, 40'h94141444, 4, 7};
        vecs[7] = '{1'b0, 7'h50, 8'h02, 8'h03, 8'h24, 8'h00, 0, 1'b0, 8'h00, 1'b1, 1'b0, 32'hA0, 1, 40'h9444, 2, 2};

        repeat (3) @(negedge clock);
        chk("reset_outs", 48'({sb_stb, cmd_ready, rsp_valid, rsp_nack, rsp_timeout, rsp_rdata}), 48'd0);
        reset = 1'b1;
        check_init("init");

        for (int i = 0; i < 8; i++) run_vec(i);

        // slow ack plus reset while polling SR
        ack_delay = 5;
        @(negedge clock);
        log_q.delete();
        sr_val = 8'h04;
        sr_pre = 1000;
        cmd_rw = 1'b0;
        cmd_dev = 7'h48;
        cmd_reg = 8'h01;
        cmd_wdata = 8'hA5;
        cmd_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 500 && !ok; k++) begin
            if (cmd_ready) ok = 1;
            else @(negedge clock);
        end
        chk("rst_accept", 48'(ok), 48'd1);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clock);
            ok = sb_stb && sb_adr == 8'h1C;
        end
        chk("rst_reach_poll", 48'(ok), 48'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_abort", 48'({sb_stb, cmd_ready, rsp_valid, rsp_nack, rsp_timeout, rsp_rdata}), 48'd0);
        log_q.delete();
        @(negedge clock);
        reset = 1'b1;
        check_init("reinit");
        run_vec(0);
        run_vec(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
